// File: rtl/seq_mult4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult4_pkg
// Brief    : Shared state encodings and iteration count for iterative units.
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult4_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int MULT_ITERS = 4;

    // Counter value seen on the final CALC edge.
    localparam logic [2:0] C_LAST_ITER = 3'(MULT_ITERS - 1);

endpackage
`default_nettype wire

// File: rtl/seq_mult4_adder.sv
`default_nettype none
// ============================================================================
// Module   : adder4bits
// Brief    : 4-bit unsigned ripple-carry adder with carry out as sum bit 4.
// Revision : 1.0 - initial release
// ============================================================================
module adder4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] s
);

    logic [4:0] w_carry;

    assign w_carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_bit
            assign s[i]         = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign s[4] = w_carry[4];

endmodule
`default_nettype wire

// File: rtl/seq_mult4.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult4
// Brief    : Sequential 4x4 unsigned shift-add multiplier, 4 CALC iterations.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult4
    import seq_mult4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_m;
    logic [3:0] r_a;
    logic [3:0] r_q;
    logic [2:0] r_cnt;
    logic [7:0] r_p;
    logic       r_done;

    logic [3:0] w_addend;
    logic [4:0] w_sum;
    logic       w_last;

    assign w_addend = r_q[0] ? r_m : 4'b0000;
    assign w_last   = (r_cnt == C_LAST_ITER);

    adder4bits u_adder (
        .a (r_a),
        .b (w_addend),
        .s (w_sum)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_m     <= 4'd0;
            r_a     <= 4'd0;
            r_q     <= 4'd0;
            r_cnt   <= 3'd0;
            r_p     <= 8'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m   <= a;
                        r_q   <= b;
                        r_a   <= 4'd0;
                        r_cnt <= 3'd0;
                    end
                end
                S_CALC: begin
                    // Carry re-enters as the new MSB, so no product bit is lost.
                    {r_a, r_q} <= {w_sum, r_q[3:1]};
                    r_cnt      <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_p    <= {w_sum, r_q[3:1]};
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_CALC);
    assign done = r_done;
    assign p    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult4.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult4
// Brief    : Directed vector table plus multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int n_vec     = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int exp_dones = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs [10];

    seq_mult4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Drive a start at the next negedge; returns 1 ns after the accepting edge.
    task automatic launch(input logic [3:0] ta, input logic [3:0] tb_v);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    // Wait for done; exp_lat counts edges from the current point to the edge
    // after which done is high.
    task automatic wait_done(input logic [7:0] exp_p, input int exp_lat, input string nm);
        int n;
        bit seen;
        seen = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk({nm, "_done_timeout"}, 0, 1);
        end else begin
            exp_dones++;
            chk({nm, "_latency"}, n, exp_lat);
            chk({nm, "_p"}, int'(p), int'(exp_p));
            chk({nm, "_busy_in_done"}, int'(busy), 0);
        end
    endtask

    initial begin
        vecs[0] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
        vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'd225};
        vecs[2] = '{a: 4'd3,  b: 4'd5,  p: 8'd15};
        vecs[3] = '{a: 4'd6,  b: 4'd9,  p: 8'd54};
        vecs[4] = '{a: 4'd1,  b: 4'd1,  p: 8'd1};
        vecs[5] = '{a: 4'd15, b: 4'd1,  p: 8'd15};
        vecs[6] = '{a: 4'd12, b: 4'd10, p: 8'd120};
        vecs[7] = '{a: 4'd8,  b: 4'd8,  p: 8'd64};
        vecs[8] = '{a: 4'd9,  b: 4'd0,  p: 8'd0};
        vecs[9] = '{a: 4'd7,  b: 4'd13, p: 8'd91};

        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_p", int'(p), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_no_done", done_cnt, 0);

        // Directed table; start-to-done is 4 edges after the accepting edge
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done(vecs[i].p, 4, $sformatf("vec%0d", i));
            @(posedge clk);
        end

        // Start during CALC is ignored
        launch(4'd6, 4'd9);
        @(posedge clk);
        #1;
        a     = 4'd7;
        b     = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(8'd54, 2, "start_in_calc");

        // Start during the DONE cycle is ignored
        a     = 4'd7;
        b     = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("start_ignored_dones", done_cnt, exp_dones);
        chk("start_ignored_p", int'(p), 54);
        chk("start_ignored_busy", int'(busy), 0);

        // Reset mid-operation sampled at CALC edge k+2
        launch(4'd15, 4'd15);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_p", int'(p), 0);
        chk("midrst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt, exp_dones);
        launch(4'd2, 4'd3);
        wait_done(8'd6, 4, "after_rst");
        @(posedge clk);

        // Operands changing while busy must not affect the result
        launch(4'd11, 4'd13);
        repeat (3) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        wait_done(8'd143, 1, "operand_hold");
        @(posedge clk);

        // Exhaustive at maximum rate: next start accepted the edge after DONE
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                launch(4'(ia), 4'(ib));
                wait_done(8'(ia * ib), 4, $sformatf("ex_%0dx%0d", ia, ib));
                @(posedge clk);
            end
        end
        @(posedge clk);
        #1;
        chk("exhaustive_done_count", done_cnt, exp_dones);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
